ctrl_pipe: RTL and testbench

Carries the decoded control bundle from the instruction decoder in ID through the EX, MEM and WB stages of the five-stage MIPS pipeline. It is the consumer end of the decoder's control interface. It owns the per-stage valid bits, destination-register tracking, load-use hazard detection (stall), flush bubble insertion and operand forwarding selects. The datapath registers for operand values live elsewhere; this block holds only control state.

---
 rtl/ctrl_pipe.sv | 177 +++++++++++++++++
 tb/tb_ctrl_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Control-side pipeline registers for a five-stage MIPS core.
//               Carries the decoded control bundle from ID through EX, MEM
//               and WB. Owns the per-stage valid bits and destination
//               tracking. Detects load-use hazards (stall), inserts bubbles
//               on flush, and produces the ALU operand forwarding selects.
//               Operand datapath registers live outside this block.
// Ports       : clk, reset (async, active-high)
//               id_*      - decoder control bundle and register fields
//               flush     - squash the ID instruction
//               stall     - hold PC and IF/ID (combinational)
//               ex_*      - EX-stage controls
//               mem_*     - MEM-stage controls
//               wb_*      - WB-stage controls and write-back index
//               fwd_a/b   - 00 regfile, 10 MEM result, 01 WB result
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int REGW = 5,
    parameter int OPW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic            id_regDst,
    input  logic            id_jump,
    input  logic            id_branch,
    input  logic            id_memRead,
    input  logic            id_memToReg,
    input  logic            id_regWrite,
    input  logic            id_ALUSrc,
    input  logic            id_memWrite,
    input  logic [OPW-1:0]  id_ALUop,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            flush,
    output logic            stall,
    output logic            ex_regDst,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_ALUSrc,
    output logic            ex_memRead,
    output logic            ex_memWrite,
    output logic [OPW-1:0]  ex_ALUop,
    output logic            mem_memRead,
    output logic            mem_memWrite,
    output logic            wb_regWrite,
    output logic            wb_memToReg,
    output logic [REGW-1:0] wb_dest,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    localparam logic [1:0]      c_FWD_RF  = 2'b00;
    localparam logic [1:0]      c_FWD_MEM = 2'b10;
    localparam logic [1:0]      c_FWD_WB  = 2'b01;
    localparam logic [REGW-1:0] c_ZERO    = '0;

    // EX stage
    logic            r_ex_valid, r_ex_regDst, r_ex_branch, r_ex_jump;
    logic            r_ex_ALUSrc, r_ex_memRead, r_ex_memWrite;
    logic            r_ex_memToReg, r_ex_regWrite;
    logic [OPW-1:0]  r_ex_ALUop;
    logic [REGW-1:0] r_ex_dest, r_ex_rs, r_ex_rt;
    // MEM stage
    logic            r_mem_valid, r_mem_memRead, r_mem_memWrite;
    logic            r_mem_memToReg, r_mem_regWrite;
    logic [REGW-1:0] r_mem_dest;
    // WB stage
    logic            r_wb_valid, r_wb_memToReg, r_wb_regWrite;
    logic [REGW-1:0] r_wb_dest;

    logic [REGW-1:0] w_id_dest;
    logic            w_uses_rt;
    logic            w_hazard;
    logic            w_ex_load;

    // A non-writing instruction carries dest 0 so it can never match
    // a hazard or forwarding comparison downstream.
    assign w_id_dest = id_regWrite ? (id_regDst ? id_rd : id_rt) : c_ZERO;
    assign w_uses_rt = ~id_ALUSrc | id_memWrite;

    assign w_hazard = r_ex_valid & r_ex_memRead & (r_ex_dest != c_ZERO) & id_valid &
                      ((r_ex_dest == id_rs) | (w_uses_rt & (r_ex_dest == id_rt)));
    assign stall     = w_hazard & ~flush;
    assign w_ex_load = id_valid & ~flush & ~w_hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_regDst    <= 1'b0;
            r_ex_branch    <= 1'b0;
            r_ex_jump      <= 1'b0;
            r_ex_ALUSrc    <= 1'b0;
            r_ex_memRead   <= 1'b0;
            r_ex_memWrite  <= 1'b0;
            r_ex_memToReg  <= 1'b0;
            r_ex_regWrite  <= 1'b0;
            r_ex_ALUop     <= '0;
            r_ex_dest      <= '0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_memRead  <= 1'b0;
            r_mem_memWrite <= 1'b0;
            r_mem_memToReg <= 1'b0;
            r_mem_regWrite <= 1'b0;
            r_mem_dest     <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_memToReg  <= 1'b0;
            r_wb_regWrite  <= 1'b0;
            r_wb_dest      <= '0;
        end else begin
            // Older instructions always retire, regardless of stall/flush.
            r_wb_valid     <= r_mem_valid;
            r_wb_memToReg  <= r_mem_memToReg;
            r_wb_regWrite  <= r_mem_regWrite;
            r_wb_dest      <= r_mem_dest;
            r_mem_valid    <= r_ex_valid;
            r_mem_memRead  <= r_ex_memRead;
            r_mem_memWrite <= r_ex_memWrite;
            r_mem_memToReg <= r_ex_memToReg;
            r_mem_regWrite <= r_ex_regWrite;
            r_mem_dest     <= r_ex_dest;
            // Bubbles load explicit zeros so decoder don't-cares never leak.
            r_ex_valid     <= w_ex_load;
            r_ex_regDst    <= w_ex_load & id_regDst;
            r_ex_branch    <= w_ex_load & id_branch;
            r_ex_jump      <= w_ex_load & id_jump;
            r_ex_ALUSrc    <= w_ex_load & id_ALUSrc;
            r_ex_memRead   <= w_ex_load & id_memRead;
            r_ex_memWrite  <= w_ex_load & id_memWrite;
            r_ex_memToReg  <= w_ex_load & id_memToReg;
            r_ex_regWrite  <= w_ex_load & id_regWrite;
            r_ex_ALUop     <= w_ex_load ? id_ALUop  : '0;
            r_ex_dest      <= w_ex_load ? w_id_dest : c_ZERO;
            r_ex_rs        <= w_ex_load ? id_rs     : c_ZERO;
            r_ex_rt        <= w_ex_load ? id_rt     : c_ZERO;
        end
    end

    assign ex_regDst    = r_ex_valid & r_ex_regDst;
    assign ex_branch    = r_ex_valid & r_ex_branch;
    assign ex_jump      = r_ex_valid & r_ex_jump;
    assign ex_ALUSrc    = r_ex_valid & r_ex_ALUSrc;
    assign ex_memRead   = r_ex_valid & r_ex_memRead;
    assign ex_memWrite  = r_ex_valid & r_ex_memWrite;
    assign ex_ALUop     = r_ex_valid ? r_ex_ALUop : '0;
    assign mem_memRead  = r_mem_valid & r_mem_memRead;
    assign mem_memWrite = r_mem_valid & r_mem_memWrite;
    assign wb_regWrite  = r_wb_valid & r_wb_regWrite;
    assign wb_memToReg  = r_wb_valid & r_wb_memToReg;
    assign wb_dest      = r_wb_valid ? r_wb_dest : c_ZERO;

    // MEM result is newer than WB, so it takes priority.
    always_comb begin
        fwd_a = c_FWD_RF;
        fwd_b = c_FWD_RF;
        if (r_ex_valid && r_ex_rs != c_ZERO) begin
            if (r_mem_valid && r_mem_regWrite && r_mem_dest == r_ex_rs)
                fwd_a = c_FWD_MEM;
            else if (r_wb_valid && r_wb_regWrite && r_wb_dest == r_ex_rs)
                fwd_a = c_FWD_WB;
        end
        if (r_ex_valid && r_ex_rt != c_ZERO) begin
            if (r_mem_valid && r_mem_regWrite && r_mem_dest == r_ex_rt)
                fwd_b = c_FWD_MEM;
            else if (r_wb_valid && r_wb_regWrite && r_wb_dest == r_ex_rt)
                fwd_b = c_FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe
// Description : Self-checking bench for ctrl_pipe. Directed vector table for
//               the forwarding/stall/flush scenarios, a reset-mid-operation
//               sequence, and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_regDst, id_jump, id_branch, id_memRead;
    logic       id_memToReg, id_regWrite, id_ALUSrc, id_memWrite;
    logic [2:0] id_ALUop;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       flush;
    logic       stall;
    logic       ex_regDst, ex_branch, ex_jump, ex_ALUSrc, ex_memRead, ex_memWrite;
    logic [2:0] ex_ALUop;
    logic       mem_memRead, mem_memWrite, wb_regWrite, wb_memToReg;
    logic [4:0] wb_dest;
    logic [1:0] fwd_a, fwd_b;

    always #5 clk = ~clk;

    ctrl_pipe #(.REGW(5), .OPW(3)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_regDst(id_regDst), .id_jump(id_jump),
        .id_branch(id_branch), .id_memRead(id_memRead), .id_memToReg(id_memToReg),
        .id_regWrite(id_regWrite), .id_ALUSrc(id_ALUSrc), .id_memWrite(id_memWrite),
        .id_ALUop(id_ALUop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .stall(stall),
        .ex_regDst(ex_regDst), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_ALUSrc(ex_ALUSrc), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_ALUop(ex_ALUop), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg), .wb_dest(wb_dest),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    typedef struct packed {
        logic       valid, regDst, jump, branch, memRead, memToReg, regWrite, ALUSrc, memWrite;
        logic [2:0] op;
        logic [4:0] rs, rt, rd;
        logic       flush;
    } id_t;

    // One in-flight instruction as the model sees it.
    typedef struct packed {
        logic       v, regDst, branch, jump, ALUSrc, memRead, memWrite, memToReg, regWrite;
        logic [2:0] op;
        logic [4:0] dest, rs, rt;
    } slot_t;

    typedef struct packed {
        id_t        in;
        logic       e_stall;
        logic [1:0] e_fa, e_fb;
        logic [4:0] e_wbd;
        logic       e_exmr;
    } vec_t;

    localparam int K_NOP = 0, K_R = 1, K_LW = 2, K_SW = 3, K_ADDI = 4;

    int    n_total = 0;
    int    n_pass  = 0;
    id_t   cur;
    slot_t m [3];   // 0 = EX, 1 = MEM, 2 = WB
    vec_t  tbl [23];

    function automatic id_t ins(int kind, int rs, int rt, int rd, bit fl);
        id_t r = '0;
        r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.flush = fl;
        case (kind)
            K_R:    begin r.valid = 1; r.regDst = 1; r.regWrite = 1; r.op = 3'b010; end
            K_LW:   begin r.valid = 1; r.ALUSrc = 1; r.memRead = 1; r.memToReg = 1; r.regWrite = 1; end
            K_SW:   begin r.valid = 1; r.ALUSrc = 1; r.memWrite = 1; end
            K_ADDI: begin r.valid = 1; r.ALUSrc = 1; r.regWrite = 1; r.op = 3'b011; end
            default: r.valid = 0;
        endcase
        return r;
    endfunction

    function automatic vec_t vr(id_t in, bit s, int fa, int fb, int wbd, bit mr);
        vec_t v;
        v.in = in; v.e_stall = s; v.e_fa = 2'(fa); v.e_fb = 2'(fb);
        v.e_wbd = 5'(wbd); v.e_exmr = mr;
        return v;
    endfunction

    function automatic logic [22:0] dut_out();
        return {stall, ex_regDst, ex_branch, ex_jump, ex_ALUSrc, ex_memRead, ex_memWrite,
                ex_ALUop, mem_memRead, mem_memWrite, wb_regWrite, wb_memToReg, wb_dest,
                fwd_a, fwd_b};
    endfunction

    function automatic bit model_stall();
        bit reads_rt = !cur.ALUSrc || cur.memWrite;
        bit dep = (m[0].dest == cur.rs) || (reads_rt && m[0].dest == cur.rt);
        return m[0].v && m[0].memRead && m[0].dest != 0 && cur.valid && dep && !cur.flush;
    endfunction

    // Which older instruction produces register r, if any.
    function automatic logic [1:0] src_of(logic [4:0] r);
        if (!m[0].v || r == 0) return 2'b00;
        if (m[1].v && m[1].regWrite && m[1].dest == r) return 2'b10;
        if (m[2].v && m[2].regWrite && m[2].dest == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [22:0] model_out();
        slot_t e = m[0], me = m[1], w = m[2];
        return {model_stall(), e.regDst, e.branch, e.jump, e.ALUSrc, e.memRead, e.memWrite,
                e.op, me.memRead, me.memWrite, w.regWrite, w.memToReg,
                (w.v ? w.dest : 5'd0), src_of(e.rs), src_of(e.rt)};
    endfunction

    task automatic chk(string name, logic [22:0] got, logic [22:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic apply_check(id_t in);
        cur = in;
        id_valid = in.valid; id_regDst = in.regDst; id_jump = in.jump; id_branch = in.branch;
        id_memRead = in.memRead; id_memToReg = in.memToReg; id_regWrite = in.regWrite;
        id_ALUSrc = in.ALUSrc; id_memWrite = in.memWrite; id_ALUop = in.op;
        id_rs = in.rs; id_rt = in.rt; id_rd = in.rd; flush = in.flush;
        #1;
        chk("model", dut_out(), model_out());
    endtask

    // Clock edge: retire WB, shift, and admit ID unless stalled/flushed/empty.
    task automatic adv();
        slot_t nx = '0;
        if (cur.valid && !cur.flush && !model_stall()) begin
            nx.v = 1; nx.regDst = cur.regDst; nx.branch = cur.branch; nx.jump = cur.jump;
            nx.ALUSrc = cur.ALUSrc; nx.memRead = cur.memRead; nx.memWrite = cur.memWrite;
            nx.memToReg = cur.memToReg; nx.regWrite = cur.regWrite; nx.op = cur.op;
            nx.dest = cur.regWrite ? (cur.regDst ? cur.rd : cur.rt) : 5'd0;
            nx.rs = cur.rs; nx.rt = cur.rt;
        end
        @(posedge clk);
        m[2] = m[1]; m[1] = m[0]; m[0] = nx;
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) m[i] = '0;
    endtask

    initial begin
        id_t r;
        tbl[0]  = vr(ins(K_R, 1, 2, 3, 0),    0, 0, 0, 0, 0);
        tbl[1]  = vr(ins(K_R, 3, 5, 4, 0),    0, 0, 0, 0, 0);
        tbl[2]  = vr(ins(K_R, 3, 7, 6, 0),    0, 2, 0, 0, 0);
        tbl[3]  = vr(ins(K_NOP, 0, 0, 0, 0),  0, 1, 0, 3, 0);
        tbl[4]  = vr(ins(K_NOP, 0, 0, 0, 0),  0, 0, 0, 4, 0);
        tbl[5]  = vr(ins(K_NOP, 0, 0, 0, 0),  0, 0, 0, 6, 0);
        tbl[6]  = vr(ins(K_LW, 1, 2, 0, 0),   0, 0, 0, 0, 0);
        tbl[7]  = vr(ins(K_R, 2, 5, 4, 0),    1, 0, 0, 0, 1);
        tbl[8]  = vr(ins(K_R, 2, 5, 4, 0),    0, 0, 0, 0, 0);
        tbl[9]  = vr(ins(K_LW, 1, 2, 0, 0),   0, 1, 0, 2, 0);
        tbl[10] = vr(ins(K_SW, 1, 2, 0, 0),   1, 0, 0, 0, 1);
        tbl[11] = vr(ins(K_SW, 1, 2, 0, 0),   0, 0, 0, 4, 0);
        tbl[12] = vr(ins(K_LW, 1, 2, 0, 0),   0, 0, 1, 2, 0);
        tbl[13] = vr(ins(K_ADDI, 6, 4, 0, 0), 0, 0, 0, 0, 1);
        tbl[14] = vr(ins(K_LW, 1, 2, 0, 0),   0, 0, 0, 0, 0);
        tbl[15] = vr(ins(K_R, 2, 5, 4, 1),    0, 0, 1, 2, 1);
        tbl[16] = vr(ins(K_NOP, 0, 0, 0, 0),  0, 0, 0, 4, 0);
        tbl[17] = vr(ins(K_NOP, 0, 0, 0, 0),  0, 0, 0, 2, 0);
        tbl[18] = vr(ins(K_ADDI, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        tbl[19] = vr(ins(K_R, 0, 0, 4, 0),    0, 0, 0, 0, 0);
        tbl[20] = vr(ins(K_NOP, 0, 0, 0, 0),  0, 0, 0, 0, 0);
        tbl[21] = vr(ins(K_NOP, 0, 0, 0, 0),  0, 0, 0, 0, 0);
        tbl[22] = vr(ins(K_NOP, 0, 0, 0, 0),  0, 0, 0, 4, 0);

        // Power-on reset
        model_clear();
        reset = 1'b1;
        apply_check(ins(K_NOP, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", dut_out(), 23'd0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 23; i++) begin
            apply_check(tbl[i].in);
            chk($sformatf("stall[%0d]", i),  23'(stall),      23'(tbl[i].e_stall));
            chk($sformatf("fwd_a[%0d]", i),  23'(fwd_a),      23'(tbl[i].e_fa));
            chk($sformatf("fwd_b[%0d]", i),  23'(fwd_b),      23'(tbl[i].e_fb));
            chk($sformatf("wbdest[%0d]", i), 23'(wb_dest),    23'(tbl[i].e_wbd));
            chk($sformatf("exmr[%0d]", i),   23'(ex_memRead), 23'(tbl[i].e_exmr));
            adv();
        end
        // LW from the flush vector retired with its write-back controls.
        apply_check(ins(K_NOP, 0, 0, 0, 0));
        adv();

        // Reset mid-operation with live EX/MEM state and a pending stall
        apply_check(ins(K_R, 1, 2, 3, 0));
        adv();
        apply_check(ins(K_LW, 3, 5, 0, 0));
        adv();
        apply_check(ins(K_R, 5, 5, 6, 0));
        chk("pre_reset_stall", 23'(stall), 23'd1);
        chk("pre_reset_fwd_a", 23'(fwd_a), 23'd2);
        #2 reset = 1'b1;
        #1;
        chk("reset_async", dut_out(), 23'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        apply_check(ins(K_R, 5, 5, 6, 0));
        chk("post_reset_stall", 23'(stall), 23'd0);
        adv();
        apply_check(ins(K_NOP, 0, 0, 0, 0));
        chk("post_reset_sample", {20'd0, ex_regDst, ex_ALUop[1:0]}, {20'd0, 1'b1, 2'b10});
        adv();

        // Randomized traffic; a stalled ID instruction is held by the front end.
        for (int n = 0; n < 600; n++) begin
            bit hold = model_stall();
            if (hold) r = cur;
            else begin
                r = id_t'({$urandom, $urandom});
                r.valid = ($urandom_range(0, 3) != 0);
                r.rs = 5'($urandom_range(0, 3));
                r.rt = 5'($urandom_range(0, 3));
                r.rd = 5'($urandom_range(0, 3));
            end
            r.flush = ($urandom_range(0, 7) == 0);
            apply_check(r);
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
